// File: rtl/dmem_pkg.sv
// Shared data-memory constants and the read-response tag that travels
// alongside a granted read until its data comes back from dmem.
package dmem_pkg;

  localparam int DMEM_BYTES = 128;
  localparam int DMEM_DW    = 32;
  localparam int DMEM_BE_W  = 4;

  typedef struct packed {
    logic valid;
    logic id;    // requester that owns the response: 0 = LSU, 1 = DMA
    logic err;   // out-of-range read; data is forced to zero on return
  } rd_tag_t;

endpackage

// File: rtl/rd_return_pipe.sv
// RD_LAT-deep shift register of read tags, aligned with the dmem read latency.
// The tail stage is decoded into per-port rvalid/err strobes.
module rd_return_pipe
  import dmem_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  logic       id_i,
  input  logic       err_i,
  output logic [1:0] rvalid_o,
  output logic [1:0] rerr_o
);

  rd_tag_t pipe_q [RD_LAT];
  rd_tag_t tag_d;
  rd_tag_t tail;

  assign tag_d = '{valid: push_i, id: id_i, err: err_i};
  assign tail  = pipe_q[RD_LAT-1];

  // NOTE: every stage is reset, not just the head, because a stale valid bit
  // anywhere in the chain would surface as a phantom response after reset.
  // NOTE: non-blocking assignments make each stage sample the previous
  // stage's old value, which is what turns this loop into a shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_d;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Responses are masked while reset is high so nothing in flight escapes.
  always_comb begin
    rvalid_o = '0;
    rerr_o   = '0;
    if (tail.valid && !reset) begin
      rvalid_o[tail.id] = 1'b1;
      rerr_o[tail.id]   = tail.err;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory port between
// the processor LSU (port 0) and the DMA engine (port 1).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = DMEM_DW,
  parameter int RD_LAT    = 1,
  parameter int MEM_BYTES = DMEM_BYTES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p0_req,
  input  logic [AW-1:0]        p0_addr,
  input  logic [DW-1:0]        p0_wdata,
  input  logic [DMEM_BE_W-1:0] p0_we,
  output logic                 p0_gnt,
  output logic                 p0_rvalid,
  output logic [DW-1:0]        p0_rdata,
  output logic                 p0_err,
  input  logic                 p1_req,
  input  logic [AW-1:0]        p1_addr,
  input  logic [DW-1:0]        p1_wdata,
  input  logic [DMEM_BE_W-1:0] p1_we,
  output logic                 p1_gnt,
  output logic                 p1_rvalid,
  output logic [DW-1:0]        p1_rdata,
  output logic                 p1_err,
  output logic [AW-1:0]        mem_daddr,
  output logic [DW-1:0]        mem_dwdata,
  output logic [DMEM_BE_W-1:0] mem_we,
  input  logic [DW-1:0]        mem_drdata
);

  logic                 last_gnt_q, last_gnt_d;
  logic [AW-1:0]        daddr_q;
  logic [DW-1:0]        dwdata_q;
  logic                 p0_oor, p1_oor;
  logic                 any_gnt, win_oor, win_legal;
  logic [AW-1:0]        win_addr;
  logic [DW-1:0]        win_wdata;
  logic [DMEM_BE_W-1:0] win_we;
  logic [1:0]           rvalid, rerr;

  assign p0_oor = p0_addr >= AW'(MEM_BYTES);
  assign p1_oor = p1_addr >= AW'(MEM_BYTES);

  // NOTE: both grants get a default before any branch so this block stays
  // purely combinational; a missing default would infer a latch.
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!reset) begin
      if (p0_req && p1_req) begin
        p0_gnt = last_gnt_q;
        p1_gnt = !last_gnt_q;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end
  end

  assign any_gnt    = p0_gnt || p1_gnt;
  assign last_gnt_d = p1_gnt ? 1'b1 : (p0_gnt ? 1'b0 : last_gnt_q);

  assign win_addr  = p1_gnt ? p1_addr  : p0_addr;
  assign win_wdata = p1_gnt ? p1_wdata : p0_wdata;
  assign win_we    = p1_gnt ? p1_we    : p0_we;
  assign win_oor   = p1_gnt ? p1_oor   : p0_oor;
  assign win_legal = any_gnt && !win_oor;

  // Idle and out-of-range cycles hold the bus so dmem never sees a stray access.
  assign mem_daddr  = win_legal ? win_addr  : daddr_q;
  assign mem_dwdata = win_legal ? win_wdata : dwdata_q;
  assign mem_we     = win_legal ? win_we    : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= 1'b1;
      daddr_q    <= '0;
      dwdata_q   <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      daddr_q    <= mem_daddr;
      dwdata_q   <= mem_dwdata;
    end
  end

  rd_return_pipe #(.RD_LAT(RD_LAT)) u_rd_return_pipe (
    .clk      (clk),
    .reset    (reset),
    .push_i   (any_gnt && (win_we == '0)),
    .id_i     (p1_gnt),
    .err_i    (win_oor),
    .rvalid_o (rvalid),
    .rerr_o   (rerr)
  );

  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = (rvalid[0] && !rerr[0]) ? mem_drdata : '0;
  assign p1_rdata  = (rvalid[1] && !rerr[1]) ? mem_drdata : '0;

  // Write errors flag with the grant; read errors flag with the response.
  assign p0_err = (p0_gnt && p0_oor && (p0_we != '0)) || rerr[0];
  assign p1_err = (p1_gnt && p1_oor && (p1_we != '0)) || rerr[1];

endmodule
